computational_unit_par: RTL and testbench
=========================================

COMPUTATIONAL_UNIT_PAR -- requirements
Module: computational_unit_par

Interface
REQ-001 SHALL have parameter W, default 4: data width of every register, data_bus and pin input.
REQ-002 SHALL have parameter MUL_LAT, default W: multiply cycles from start to result, legal range 1..W.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sync_reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_sel, x_sel, y_sel, input, 1 each: i load/increment select, ALU x and y operand selects.
REQ-006 SHALL have port i_pins, dm, input, W each: external pin data and data-memory data.
REQ-007 SHALL have port nibble_ir, input, 4: ALU function code and immediate; bits [W-1:0] are the immediate, zero-extended when W>4.
REQ-008 SHALL have port source_sel, input, 4: data_bus source select.
REQ-009 SHALL have port reg_en, input, 9: write enables [0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]unused [8]o_reg.
REQ-010 SHALL have port data_bus, output, W: selected source value.
REQ-011 SHALL have port x0, x1, y0, y1, r, m, i, o_reg, output, W each: register contents.
REQ-012 SHALL have port r_eq_0, carry, output, 1 each: zero flag and carry/borrow flag.
REQ-013 SHALL have port busy, output, 1: high while a multiply is in progress.
REQ-014 SHALL have port mul_done, output, 1: one-cycle pulse in the cycle r takes a multiply result.

Function
REQ-015 SHALL drive data_bus combinationally from source_sel: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 nibble_ir, 9 i_pins, 10-15 zero.
REQ-016 SHALL load x0, x1, y0, y1, m and o_reg from data_bus on each edge where the matching reg_en bit is 1, and otherwise hold them.
REQ-017 SHALL update i only when reg_en[6]=1: load data_bus when i_sel=0, and load (i+m) mod 2^W when i_sel=1.
REQ-018 SHALL take operand x from x1 when x_sel=1 (else x0), and operand y from y1 when y_sel=1 (else y0).
REQ-019 SHALL execute single-cycle ALU ops when reg_en[4]=1 and busy=0, per nibble_ir[2:0]: 0 gives -x; 1 gives x-y; 2 gives x+y; 5 gives x^y; 6 gives x&y; 7 gives ~x.
REQ-020 SHALL treat nibble_ir=8 and nibble_ir=F as NOPs: r and carry hold.
REQ-021 SHALL set carry for single-cycle ops as follows: add sets it to bit W of x+y; sub sets it to 1 when x<y (borrow); neg sets it to 1 when x!=0; logic ops clear it.
REQ-022 SHALL start an unsigned multiply when nibble_ir[2:0] is 3 (high half) or 4 (low half), reg_en[4]=1 and busy=0: x, y and the half select latch in that edge, and busy rises.
REQ-023 SHALL complete a multiply exactly MUL_LAT edges after the start edge: r loads product[2W-1:W] for op 3 or product[W-1:0] for op 4, carry clears, mul_done pulses for one cycle, and busy falls in the same cycle.
REQ-024 SHALL implement the multiply as an iterative shift-add; changes to x0..y1 or x_sel/y_sel while busy do not affect the result.
REQ-025 SHALL ignore reg_en[4] while busy=1: no new start and no ALU write; all other register writes proceed normally.
REQ-026 SHALL drive r_eq_0 combinationally as 1 exactly when r==0.
REQ-027 SHALL make all arithmetic wrap modulo 2^W.

Reset
REQ-028 SHALL, on sync_reset=1, immediately clear x0, x1, y0, y1, r, m, i, o_reg, carry, busy, mul_done and the multiplier state to 0, giving r_eq_0=1.
REQ-029 SHALL, on sync_reset asserted mid-multiply, abort the multiply with no result write and no mul_done pulse.
REQ-030 SHALL begin normal operation on the first rising edge after sync_reset deasserts.

Verification
REQ-031 SHALL pass reset: assert sync_reset mid-cycle -> all outputs 0 before the next edge, r_eq_0=1.
REQ-032 SHALL pass add with carry (W=4): x0=9, y0=8, op 2 -> r=1, carry=1, r_eq_0=0.
REQ-033 SHALL pass multiply (W=4): x0=7, y0=6, op 3 -> busy for 4 cycles, then r=2 and mul_done pulse; op 4 -> r=A.
REQ-034 SHALL pass operand stability: during the multiply, x0 loaded with F and reg_en[4] pulsed with op 2 -> result unchanged, no extra start.
REQ-035 SHALL pass abort: sync_reset two cycles into a multiply -> busy=0, r=0, no mul_done.
REQ-036 SHALL pass index wrap (W=8): i=FE, m=3, i_sel=1 -> i=01; source_sel 10-15 -> data_bus=0.

Source files
------------

// File: rtl/computational_unit_par.sv
// computational_unit_par: register file, data bus mux, single-cycle ALU and
// iterative shift-add multiplier with busy/mul_done handshake.
`default_nettype none

module computational_unit_par #(
   parameter int W       = 4,
   parameter int MUL_LAT = W
) (
   input  logic         clk,
   input  logic         sync_reset,
   input  logic         i_sel,
   input  logic         x_sel,
   input  logic         y_sel,
   input  logic [W-1:0] i_pins,
   input  logic [W-1:0] dm,
   input  logic [3:0]   nibble_ir,
   input  logic [3:0]   source_sel,
   input  logic [8:0]   reg_en,
   output logic [W-1:0] data_bus,
   output logic [W-1:0] x0,
   output logic [W-1:0] x1,
   output logic [W-1:0] y0,
   output logic [W-1:0] y1,
   output logic [W-1:0] r,
   output logic [W-1:0] m,
   output logic [W-1:0] i,
   output logic [W-1:0] o_reg,
   output logic         r_eq_0,
   output logic         carry,
   output logic         busy,
   output logic         mul_done
);

   // Multiplier bits retired per cycle so that MUL_LAT steps cover all W bits
   localparam int BPS = (W + MUL_LAT - 1) / MUL_LAT;
   localparam int CW  = $clog2(MUL_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    x0_q, x1_q, y0_q, y1_q, m_q, i_q, o_q;
   logic [W-1:0]    r_q, r_d;
   logic            carry_q, carry_d;
   logic            done_q, done_d;
   logic            hi_q, hi_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  mc_q, mc_d, acc_q, acc_d;
   logic [W-1:0]    mp_q, mp_d;

   logic [W+3:0]    imm_ext;
   logic [W-1:0]    imm;
   logic [W-1:0]    x_op, y_op;
   logic [W:0]      sum;
   logic            alu_nop;
   logic [2*W-1:0]  mc_t, acc_t;
   logic [W-1:0]    mp_t;

   // Zero-extend or truncate the immediate nibble to W bits
   assign imm_ext = {{W{1'b0}}, nibble_ir};
   assign imm     = imm_ext[W-1:0];

   always_comb begin
      data_bus = '0;
      case (source_sel)
         4'd0:    data_bus = x0_q;
         4'd1:    data_bus = x1_q;
         4'd2:    data_bus = y0_q;
         4'd3:    data_bus = y1_q;
         4'd4:    data_bus = r_q;
         4'd5:    data_bus = m_q;
         4'd6:    data_bus = i_q;
         4'd7:    data_bus = dm;
         4'd8:    data_bus = imm;
         4'd9:    data_bus = i_pins;
         default: data_bus = '0;
      endcase
   end

   assign x_op    = x_sel ? x1_q : x0_q;
   assign y_op    = y_sel ? y1_q : y0_q;
   assign sum     = {1'b0, x_op} + {1'b0, y_op};
   assign alu_nop = (nibble_ir == 4'h8) || (nibble_ir == 4'hF);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      mc_d    = mc_q;
      mp_d    = mp_q;
      acc_d   = acc_q;
      mc_t    = mc_q;
      mp_t    = mp_q;
      acc_t   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (reg_en[4] && !alu_nop) begin
               case (nibble_ir[2:0])
                  3'd0: begin r_d = '0 - x_op;        carry_d = |x_op;        end
                  3'd1: begin r_d = x_op - y_op;      carry_d = (x_op < y_op); end
                  3'd2: begin r_d = sum[W-1:0];       carry_d = sum[W];       end
                  3'd5: begin r_d = x_op ^ y_op;      carry_d = 1'b0;         end
                  3'd6: begin r_d = x_op & y_op;      carry_d = 1'b0;         end
                  3'd7: begin r_d = ~x_op;            carry_d = 1'b0;         end
                  default: begin
                     // ops 3/4: operands are captured here so later writes cannot disturb them
                     state_d = S_MUL;
                     cnt_d   = CNT_INIT;
                     mc_d    = {{W{1'b0}}, x_op};
                     mp_d    = y_op;
                     acc_d   = '0;
                     hi_d    = (nibble_ir[2:0] == 3'd3);
                  end
               endcase
            end
         end
         S_MUL: begin
            for (int k = 0; k < BPS; k++) begin
               if (mp_t[0]) acc_t = acc_t + mc_t;
               mc_t = mc_t << 1;
               mp_t = mp_t >> 1;
            end
            mc_d  = mc_t;
            mp_d  = mp_t;
            acc_d = acc_t;
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               r_d     = hi_q ? acc_t[2*W-1:W] : acc_t[W-1:0];
               carry_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 1'b0;
         cnt_q   <= '0;
         mc_q    <= '0;
         mp_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         carry_q <= carry_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         acc_q   <= acc_d;
      end
   end

   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         x0_q <= '0;
         x1_q <= '0;
         y0_q <= '0;
         y1_q <= '0;
         m_q  <= '0;
         i_q  <= '0;
         o_q  <= '0;
      end else begin
         if (reg_en[0]) x0_q <= data_bus;
         if (reg_en[1]) x1_q <= data_bus;
         if (reg_en[2]) y0_q <= data_bus;
         if (reg_en[3]) y1_q <= data_bus;
         if (reg_en[5]) m_q  <= data_bus;
         if (reg_en[6]) i_q  <= i_sel ? (i_q + m_q) : data_bus;
         if (reg_en[8]) o_q  <= data_bus;
      end
   end

   assign x0       = x0_q;
   assign x1       = x1_q;
   assign y0       = y0_q;
   assign y1       = y1_q;
   assign r        = r_q;
   assign m        = m_q;
   assign i        = i_q;
   assign o_reg    = o_q;
   assign r_eq_0   = (r_q == '0);
   assign carry    = carry_q;
   assign busy     = (state_q == S_MUL);
   assign mul_done = done_q;

   logic unused_bits;
   assign unused_bits = ^{reg_en[7], imm_ext[W+3:W]};

endmodule

`default_nettype wire

// File: tb/tb_computational_unit_par.sv
// Directed bench for computational_unit_par: W=4 instance for ALU/multiply,
// W=8 instance for index wrap and unused bus selects.
`default_nettype none

module tb_computational_unit_par;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       i_sel, x_sel, y_sel;
   logic [3:0] pins, dm, nib, src;
   logic [8:0] en;
   logic [3:0] db, x0, x1, y0, y1, r, m, i, o_reg;
   logic       r_eq_0, carry, busy, mul_done;

   logic       i_sel8;
   logic [7:0] pins8, dm8;
   logic [3:0] nib8, src8;
   logic [8:0] en8;
   logic [7:0] db8, x0_8, x1_8, y0_8, y1_8, r8, m8, i8, o8;
   logic       req0_8, carry8, busy8, done8;

   int errs   = 0;
   int checks = 0;

   computational_unit_par #(.W(4)) u4 (
      .clk(clk), .sync_reset(rst), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel),
      .i_pins(pins), .dm(dm), .nibble_ir(nib), .source_sel(src), .reg_en(en),
      .data_bus(db), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i),
      .o_reg(o_reg), .r_eq_0(r_eq_0), .carry(carry), .busy(busy), .mul_done(mul_done)
   );

   computational_unit_par #(.W(8)) u8 (
      .clk(clk), .sync_reset(rst), .i_sel(i_sel8), .x_sel(x_sel), .y_sel(y_sel),
      .i_pins(pins8), .dm(dm8), .nibble_ir(nib8), .source_sel(src8), .reg_en(en8),
      .data_bus(db8), .x0(x0_8), .x1(x1_8), .y0(y0_8), .y1(y1_8), .r(r8), .m(m8), .i(i8),
      .o_reg(o8), .r_eq_0(req0_8), .carry(carry8), .busy(busy8), .mul_done(done8)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] s, input logic [3:0] n, input logic [8:0] e);
      src = s; nib = n; en = e;
      @(posedge clk); #1;
   endtask

   task automatic cyc8(input logic [3:0] s, input logic [7:0] p, input logic [8:0] e);
      src8 = s; pins8 = p; en8 = e;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; i_sel = 0; x_sel = 0; y_sel = 0;
      pins = 0; dm = 0; nib = 0; src = 4'd10; en = 0;
      i_sel8 = 0; pins8 = 0; dm8 = 0; nib8 = 0; src8 = 4'd10; en8 = 0;
      @(posedge clk); #1;
      check("init_req0", r_eq_0, 1);
      check("init_busy", busy, 0);
      rst = 1'b0;

      // add with carry
      cyc(8, 4'h9, 9'h001);
      cyc(8, 4'h8, 9'h004);
      cyc(10, 4'h2, 9'h010);
      check("add_r", r, 4'h1);
      check("add_c", carry, 1);
      check("add_req0", r_eq_0, 0);
      check("add_x0", x0, 4'h9);
      en = 0;

      // asynchronous reset mid-cycle
      #3 rst = 1'b1;
      #1;
      check("rst_x0", x0, 0);
      check("rst_y0", y0, 0);
      check("rst_r", r, 0);
      check("rst_c", carry, 0);
      check("rst_req0", r_eq_0, 1);
      check("rst_busy", busy, 0);
      check("rst_done", mul_done, 0);
      check("rst_db", db, 0);
      rst = 1'b0;

      cyc(8, 4'h7, 9'h001);
      cyc(8, 4'h6, 9'h004);
      cyc(8, 4'h3, 9'h002);
      cyc(8, 4'h5, 9'h008);
      src = 0; #1 check("db_x0", db, 4'h7);
      src = 3; #1 check("db_y1", db, 4'h5);
      dm = 4'hC; src = 7; #1 check("db_dm", db, 4'hC);
      pins = 4'hB; src = 9; #1 check("db_pins", db, 4'hB);

      // single-cycle ALU ops
      x_sel = 1; cyc(10, 4'h1, 9'h010);
      check("sub_r", r, 4'hD); check("sub_c", carry, 1);
      x_sel = 0; cyc(10, 4'h0, 9'h010);
      check("neg_r", r, 4'h9); check("neg_c", carry, 1);
      cyc(10, 4'h5, 9'h010);
      check("xor_r", r, 4'h1); check("xor_c", carry, 0);
      x_sel = 1; cyc(10, 4'h1, 9'h010); x_sel = 0;
      cyc(10, 4'h8, 9'h010);
      check("nop8_r", r, 4'hD); check("nop8_c", carry, 1);
      cyc(10, 4'hF, 9'h010);
      check("nopF_r", r, 4'hD); check("nopF_c", carry, 1);
      y_sel = 1; cyc(10, 4'h2, 9'h010); y_sel = 0;
      check("add2_r", r, 4'hC); check("add2_c", carry, 0);
      cyc(10, 4'h6, 9'h010);
      check("and_r", r, 4'h6);
      cyc(10, 4'h7, 9'h010);
      check("not_r", r, 4'h8);
      x_sel = 1; cyc(10, 4'h1, 9'h010); x_sel = 0;
      check("sub2_c", carry, 1);

      // multiply high half: 7*6 = 0x2A
      cyc(10, 4'h3, 9'h010);
      check("mulh_busy0", busy, 1);
      check("mulh_rhold", r, 4'hD);
      for (int k = 1; k < 4; k++) begin
         cyc(10, 4'h3, 9'h000);
         check("mulh_busy", busy, 1);
         check("mulh_done0", mul_done, 0);
      end
      cyc(10, 4'h3, 9'h000);
      check("mulh_r", r, 4'h2); check("mulh_c", carry, 0);
      check("mulh_done", mul_done, 1); check("mulh_busyend", busy, 0);
      cyc(10, 4'h3, 9'h000);
      check("mulh_donepulse", mul_done, 0);

      // multiply low half
      cyc(10, 4'h4, 9'h010);
      for (int k = 1; k < 4; k++) cyc(10, 4'h4, 9'h000);
      check("mull_busy", busy, 1);
      cyc(10, 4'h4, 9'h000);
      check("mull_r", r, 4'hA); check("mull_done", mul_done, 1);

      // operand stability and ignored reg_en[4] while busy
      cyc(10, 4'h3, 9'h010);
      cyc(8, 4'hF, 9'h001);
      check("stab_busy1", busy, 1);
      cyc(10, 4'h2, 9'h010);
      check("stab_rhold", r, 4'hA);
      cyc(10, 4'h2, 9'h000);
      check("stab_x0", x0, 4'hF); check("stab_busy3", busy, 1);
      cyc(10, 4'h2, 9'h000);
      check("stab_r", r, 4'h2); check("stab_done", mul_done, 1);
      cyc(10, 4'h2, 9'h000);
      check("stab_nostart", busy, 0); check("stab_r2", r, 4'h2);

      // abort by reset two cycles into a multiply
      cyc(8, 4'h7, 9'h001);
      cyc(10, 4'h4, 9'h010);
      cyc(10, 4'h4, 9'h000);
      cyc(10, 4'h4, 9'h000);
      #3 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0); check("abort_r", r, 0); check("abort_done", mul_done, 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc(10, 4'h4, 9'h000);
         check("abort_nodone", mul_done, 0);
         check("abort_r0", r, 0);
      end

      // W=8 index wrap, o_reg load and unused bus selects
      i_sel8 = 0; cyc8(9, 8'hFE, 9'h040);
      check("w8_iload", i8, 8'hFE);
      cyc8(9, 8'h03, 9'h020);
      check("w8_m", m8, 8'h03);
      i_sel8 = 1; cyc8(9, 8'h00, 9'h040); i_sel8 = 0;
      check("w8_iwrap", i8, 8'h01);
      cyc8(9, 8'h5A, 9'h101);
      check("w8_oreg", o8, 8'h5A); check("w8_x0", x0_8, 8'h5A);
      en8 = 0; dm8 = 8'hFF;
      for (int s = 10; s < 16; s++) begin
         src8 = 4'(s); #1;
         check("w8_db_zero", db8, 8'h00);
      end
      src8 = 4'd9; #1 check("w8_db_pins", db8, 8'h5A);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire
